paddle_quadrature: RTL and testbench

PADDLE_QUADRATURE -- requirements
Module: paddle_quadrature

---
 rtl/paddle_quadrature.sv | 165 ++++++++++++++++
 tb/tb_paddle_quadrature.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_quadrature.sv
// paddle_quadrature
//   Turns a mechanical quadrature encoder into a frame-stable paddle X
//   position. Each phase is synchronised, debounced, then decoded as a Gray
//   sequence; the position is clamped to [0, POS_MAX]. It is published to
//   the render stage only on frame_tick, so it never changes mid-frame.
//
// Ports
//   clk         system/pixel clock, all logic on its rising edge
//   rst_n       synchronous active-low reset
//   quadA/quadB asynchronous encoder phases
//   frame_tick  one-cycle pulse once per video frame
//   paddle_pos  paddle X position, updated only on frame_tick
//   dir         direction of the last legal step (1 = decreasing X)
//   err_cnt     saturating count of illegal double-phase transitions
module paddle_quadrature #(
  parameter int POS_MAX  = 511,
  parameter int POS_INIT = 256,
  parameter int STEP     = 2,
  parameter int DEB_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       quadA,
  input  logic       quadB,
  input  logic       frame_tick,
  output logic [9:0] paddle_pos,
  output logic       dir,
  output logic [7:0] err_cnt
);

  localparam int DEB_W  = $clog2(DEB_LEN + 1);
  localparam int INIT_W = $clog2(DEB_LEN + 4);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_LEN - 1);
  // The init window is long enough for the rest state present at reset
  // release to travel through the synchroniser and the debounce filter.
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEB_LEN + 2);

  typedef enum logic {
    INIT_CAPTURE,
    DECODE
  } DecodeState;

  DecodeState state, nextState;

  logic [1:0]        syncA, syncB;
  logic [1:0]        syncAB;
  logic [1:0]        filtAB;
  logic [1:0]        prevAB;
  logic [DEB_W-1:0]  debCnt [2];
  logic [INIT_W-1:0] initCnt;
  logic [9:0]        pos;
  logic [1:0]        phaseDelta;
  logic              stepUp, stepDown, stepIllegal;
  logic [10:0]       upSum;
  logic [9:0]        upClamp, downClamp;

  // Maps the Gray phase pattern to its index along the forward rotation
  // 00->01->11->10. The difference of two indices then gives the step.
  function automatic logic [1:0] grayIdx(input logic [1:0] ab);
    case (ab)
      2'b00:   grayIdx = 2'd0;
      2'b01:   grayIdx = 2'd1;
      2'b11:   grayIdx = 2'd2;
      default: grayIdx = 2'd3;
    endcase
  endfunction

  // Two-flop synchronisers. Bit 1 of each pair is the settled sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= {syncA[0], quadA};
      syncB <= {syncB[0], quadB};
    end
  end

  assign syncAB = {syncA[1], syncB[1]};

  // Per-phase debounce. A phase is accepted only after DEB_LEN consecutive
  // samples that disagree with the filtered value; any agreeing sample
  // restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filtAB    <= '0;
      debCnt[0] <= '0;
      debCnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syncAB[i] == filtAB[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DEB_LAST) begin
          filtAB[i] <= syncAB[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Decoder state register plus the init-window cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT_CAPTURE;
      initCnt <= '0;
    end else begin
      state <= nextState;
      if (state == INIT_CAPTURE) begin
        initCnt <= initCnt + INIT_W'(1);
      end
    end
  end

  // Stay in the capture state until the rest state has been filtered, so
  // that a non-00 rest state is taken as the reference, not as a step.
  always_comb begin
    nextState = state;
    if (state == INIT_CAPTURE && initCnt == INIT_LAST) begin
      nextState = DECODE;
    end
  end

  // Step classification and clamped arithmetic. The 11-bit sum keeps the
  // upper clamp from wrapping; the lower clamp compares before subtracting.
  always_comb begin
    phaseDelta  = grayIdx(filtAB) - grayIdx(prevAB);
    stepUp      = (state == DECODE) && (phaseDelta == 2'd1);
    stepDown    = (state == DECODE) && (phaseDelta == 2'd3);
    stepIllegal = (state == DECODE) && (phaseDelta == 2'd2);
    upSum       = {1'b0, pos} + 11'(STEP);
    upClamp     = (upSum > 11'(POS_MAX)) ? 10'(POS_MAX) : upSum[9:0];
    downClamp   = ({1'b0, pos} < 11'(STEP)) ? 10'd0
                                            : 10'({1'b0, pos} - 11'(STEP));
  end

  // Position, direction, error counter and the frame-latched output.
  // paddle_pos samples pos before this edge's update, so a step landing on
  // the frame_tick edge appears one frame later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prevAB     <= '0;
      pos        <= 10'(POS_INIT);
      paddle_pos <= 10'(POS_INIT);
      dir        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      prevAB <= filtAB;
      if (stepUp) begin
        pos <= upClamp;
        dir <= 1'b0;
      end else if (stepDown) begin
        pos <= downClamp;
        dir <= 1'b1;
      end else if (stepIllegal && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (frame_tick) begin
        paddle_pos <= pos;
      end
    end
  end

endmodule

// File: tb/tb_paddle_quadrature.sv
// tb_paddle_quadrature
//   Self-checking bench for paddle_quadrature. A behavioural model tracks
//   the pins the bench drives and the step each pin change represents on
//   the encoder wheel, and predicts position, direction and error count.
module tb_paddle_quadrature;

  localparam int POS_MAX  = 511;
  localparam int POS_INIT = 256;
  localparam int STEP     = 2;
  localparam int DEB_LEN  = 4;
  localparam int SETTLE   = DEB_LEN + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       quadA = 1'b0;
  logic       quadB = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] paddle_pos;
  logic       dir;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int expInt, expShown, expDir, expErr;
  logic [1:0] curAB;

  paddle_quadrature #(
    .POS_MAX(POS_MAX), .POS_INIT(POS_INIT), .STEP(STEP), .DEB_LEN(DEB_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB),
    .frame_tick(frame_tick), .paddle_pos(paddle_pos), .dir(dir),
    .err_cnt(err_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Bound on total run time in case the stimulus ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Forward rotation on the encoder wheel: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] fwdNext(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] fwdPrev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Effect of one settled phase change on the expected internal state.
  task automatic modelTransition(input logic [1:0] prev, input logic [1:0] cur);
    if (prev == cur) begin
      return;
    end else if (cur == fwdNext(prev)) begin
      expInt = (expInt + STEP > POS_MAX) ? POS_MAX : expInt + STEP;
      expDir = 0;
    end else if (cur == fwdPrev(prev)) begin
      expInt = (expInt < STEP) ? 0 : expInt - STEP;
      expDir = 1;
    end else begin
      expErr = (expErr == 255) ? 255 : expErr + 1;
    end
  endtask

  task automatic checkVal(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".pos"}, int'(paddle_pos), expShown);
    checkVal({tag, ".dir"}, int'(dir), expDir);
    checkVal({tag, ".err"}, int'(err_cnt), expErr);
  endtask

  // All waits end on a falling edge, which is where the bench drives
  // inputs and samples outputs.
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drivePins(input logic [1:0] ab);
    quadA = ab[1];
    quadB = ab[0];
  endtask

  // Drive a new pin state, hold it long enough to settle, update model.
  task automatic applyStimulus(input logic [1:0] ab, input int hold);
    logic [1:0] prev;
    prev = curAB;
    drivePins(ab);
    waitCycles(hold);
    modelTransition(prev, ab);
    curAB = ab;
  endtask

  // Pulse phase B for len cycles then restore it.
  task automatic pulseB(input int len);
    logic [1:0] glitched;
    glitched = curAB ^ 2'b01;
    drivePins(glitched);
    waitCycles(len);
    drivePins(curAB);
    waitCycles(SETTLE + 2);
    if (len >= DEB_LEN) begin
      modelTransition(curAB, glitched);
      modelTransition(glitched, curAB);
    end
  endtask

  task automatic frameTick();
    frame_tick = 1'b1;
    waitCycles(1);
    frame_tick = 1'b0;
    expShown = expInt;
  endtask

  task automatic modelReset();
    expInt   = POS_INIT;
    expShown = POS_INIT;
    expDir   = 0;
    expErr   = 0;
  endtask

  // Reset with the given pins held through reset and release.
  task automatic doReset(input logic [1:0] ab, input string tag);
    rst_n = 1'b0;
    drivePins(ab);
    waitCycles(3);
    modelReset();
    checkOutput(tag);
    rst_n = 1'b1;
    waitCycles(SETTLE + 2);
    curAB = ab;
  endtask

  initial begin
    logic [1:0] prev, nxt;
    int sel;

    curAB = 2'b00;
    modelReset();
    waitCycles(1);

    doReset(2'b00, "reset");
    checkOutput("afterRelease");

    // Four forward steps, then publish.
    applyStimulus(2'b01, 10);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b00, 10);
    checkOutput("fourUpBeforeTick");
    frameTick();
    checkOutput("fourUp");
    checkVal("fourUpAbs", int'(paddle_pos), 264);

    // Short glitch is rejected; a pulse of exactly DEB_LEN is accepted.
    pulseB(DEB_LEN - 1);
    frameTick();
    checkOutput("glitchShort");
    pulseB(DEB_LEN);
    frameTick();
    checkOutput("glitchFull");
    checkVal("glitchFullDir", int'(dir), 1);

    // Position-change latency, observed through dir.
    applyStimulus(fwdNext(curAB), SETTLE);
    checkVal("latencyPreDir", int'(dir), 0);
    prev = curAB;
    nxt  = fwdPrev(curAB);
    drivePins(nxt);
    waitCycles(DEB_LEN + 2);
    checkVal("dirBeforeLatency", int'(dir), 0);
    waitCycles(1);
    checkVal("dirAtLatency", int'(dir), 1);
    waitCycles(3);
    modelTransition(prev, nxt);
    curAB = nxt;

    // Step landing on the frame_tick edge shows one frame later.
    frameTick();
    prev = curAB;
    nxt  = fwdNext(curAB);
    drivePins(nxt);
    waitCycles(DEB_LEN + 2);
    frame_tick = 1'b1;
    waitCycles(1);
    frame_tick = 1'b0;
    expShown = expInt;
    modelTransition(prev, nxt);
    curAB = nxt;
    waitCycles(3);
    checkOutput("coincident");
    frameTick();
    checkOutput("afterCoincident");

    // Illegal jumps and saturation of the error counter.
    applyStimulus(curAB ^ 2'b11, SETTLE);
    frameTick();
    checkOutput("illegalOne");
    checkVal("illegalOneAbs", int'(err_cnt), 1);
    for (int i = 0; i < 300; i++) applyStimulus(curAB ^ 2'b11, SETTLE);
    frameTick();
    checkOutput("illegalSat");
    checkVal("illegalSatAbs", int'(err_cnt), 255);

    // Clamp at both ends.
    while (expInt < POS_MAX - 1) applyStimulus(fwdNext(curAB), SETTLE);
    frameTick();
    checkVal("reach510", int'(paddle_pos), 510);
    applyStimulus(fwdNext(curAB), SETTLE);
    frameTick();
    checkVal("clampMax", int'(paddle_pos), 511);
    checkOutput("clampMaxModel");
    while (expInt > 1) applyStimulus(fwdPrev(curAB), SETTLE);
    frameTick();
    checkVal("reach1", int'(paddle_pos), 1);
    applyStimulus(fwdPrev(curAB), SETTLE);
    frameTick();
    checkVal("clampMin", int'(paddle_pos), 0);
    applyStimulus(fwdPrev(curAB), SETTLE);
    applyStimulus(fwdPrev(curAB), SETTLE);
    frameTick();
    checkVal("holdMin", int'(paddle_pos), 0);
    checkVal("holdMinDir", int'(dir), 1);

    // Reset in the middle of a pending step.
    applyStimulus(fwdNext(curAB), SETTLE);
    applyStimulus(fwdNext(curAB), SETTLE);
    applyStimulus(fwdPrev(curAB), SETTLE);
    frameTick();
    checkOutput("preMidReset");
    nxt = fwdNext(curAB);
    drivePins(nxt);
    waitCycles(3);
    rst_n = 1'b0;
    waitCycles(1);
    modelReset();
    checkOutput("midReset");
    rst_n = 1'b1;
    curAB = nxt;
    waitCycles(SETTLE + 2);
    frameTick();
    checkOutput("afterMidReset");

    // Encoder resting at 11 through reset.
    doReset(2'b11, "reset11");
    frameTick();
    checkOutput("rest11");
    applyStimulus(2'b10, SETTLE);
    frameTick();
    checkVal("rest11Step", int'(paddle_pos), 258);
    checkOutput("rest11StepModel");

    // Randomised walk against the model.
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      applyStimulus(fwdNext(curAB), SETTLE + $urandom_range(0, 4));
      else if (sel <= 6) applyStimulus(fwdPrev(curAB), SETTLE + $urandom_range(0, 4));
      else if (sel == 7) applyStimulus(curAB ^ 2'b11, SETTLE + $urandom_range(0, 4));
      else if (sel == 8) pulseB($urandom_range(1, DEB_LEN - 1));
      else               frameTick();
      checkOutput("random");
    end
    frameTick();
    checkOutput("randomFinal");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
